ffcp_tx_scheduler: RTL and testbench

//  Sits between the FFCP servers and ffcp_tx, and arbitrates between two request sources:
//   - ack requests from ffcp_rx_server
//   - data requests from ffcp_tx_server

---
 rtl/ffcp_tx_scheduler_if.sv | 39 +++
 rtl/ffcp_tx_scheduler.sv | 173 +++++++++++++++++
 tb/tb_ffcp_tx_scheduler.sv | 245 ++++++++++++++++++++++++
 3 files changed

// File: rtl/ffcp_tx_scheduler_if.sv
// Request/frame/PB-RAM bundle for ffcp_tx_scheduler.
// slave is the scheduler side; master is the servers, ffcp_tx and PB RAM side.
interface ffcp_tx_scheduler_if #(
    parameter int unsigned PW = 5
);
    logic           data_req;
    logic           data_syn;
    logic [5:0]     data_index;
    logic [PW-1:0]  data_buf_pos;
    logic           ack_req;
    logic [5:0]     ack_index;
    logic           data_done;
    logic           ack_done;
    logic           tx_start;
    logic [1:0]     tx_type;
    logic [5:0]     tx_index;
    logic           tx_upstream_readclk;
    logic           tx_inclk;
    logic [7:0]     tx_in;
    logic           tx_in_done;
    logic           tx_done;
    logic [PW+9:0]  pb_raddr;
    logic [7:0]     pb_rdata;
    logic           timeout;

    modport master (
        output data_req, data_syn, data_index, data_buf_pos, ack_req, ack_index,
               tx_upstream_readclk, tx_done, pb_rdata,
        input  data_done, ack_done, tx_start, tx_type, tx_index, tx_inclk, tx_in,
               tx_in_done, pb_raddr, timeout
    );

    modport slave (
        input  data_req, data_syn, data_index, data_buf_pos, ack_req, ack_index,
               tx_upstream_readclk, tx_done, pb_rdata,
        output data_done, ack_done, tx_start, tx_type, tx_index, tx_inclk, tx_in,
               tx_in_done, pb_raddr, timeout
    );
endinterface

// File: rtl/ffcp_tx_scheduler.sv
// Arbitrates ack/data requests into one FFCP frame at a time, streaming msg/syn payload from PB RAM.
// Optional abort watchdog enabled by defining FFCP_TX_SCHED_WATCHDOG_EN.
module ffcp_tx_scheduler #(
    parameter int unsigned PB_QUEUE_LEN    = 32,
    parameter int unsigned DATA_LEN        = 769,
    parameter int unsigned RAM_LATENCY     = 2,
    parameter int unsigned WATCHDOG_CYCLES = 100000
) (
    input logic              clk,
    input logic              rst,
    ffcp_tx_scheduler_if.slave bus
);
    localparam int unsigned PW = $clog2(PB_QUEUE_LEN);
    localparam int unsigned OW = 10;
    localparam int unsigned CW = OW + 1;           // count must be able to hold DATA_LEN itself
    localparam int unsigned L  = RAM_LATENCY;
    localparam logic [CW-1:0] LEN  = CW'(DATA_LEN);
    localparam logic [CW-1:0] LAST = CW'(DATA_LEN - 1);

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        START     = 2'd1,
        STREAM    = 2'd2,
        WAIT_DONE = 2'd3
    } state_t;

    state_t          state;
    logic            ack_pend, data_pend, data_syn_q, cur_ack;
    logic [5:0]      ack_idx_q, data_idx_q;
    logic [PW-1:0]   data_pos_q, cur_pos;
    logic [CW-1:0]   off_q;
    logic [L-1:0]    vld_dl, last_dl;
    logic            tx_start_q, ack_done_q, data_done_q, timeout_q;
    logic [1:0]      tx_type_q;
    logic [5:0]      tx_index_q;
    logic [PW+OW-1:0] pb_raddr_q;
    logic            take_c, wd_fire_c;

    assign take_c = (state == STREAM) && bus.tx_upstream_readclk && (off_q < LEN);

`ifdef FFCP_TX_SCHED_WATCHDOG_EN
    localparam int unsigned WW = $clog2(WATCHDOG_CYCLES + 1);
    logic [WW-1:0] wd_cnt;

    // Cycles spent in the current STREAM/WAIT_DONE visit; zero on every state entry.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            wd_cnt <= '0;
        else if ((state == STREAM && !last_dl[L-1]) || state == WAIT_DONE)
            wd_cnt <= wd_cnt + WW'(1);
        else
            wd_cnt <= '0;
    end

    assign wd_fire_c = (state == STREAM || state == WAIT_DONE) &&
                       (wd_cnt == WW'(WATCHDOG_CYCLES - 1)) &&
                       !(state == WAIT_DONE && bus.tx_done);
`else
    logic wd_unused;
    assign wd_unused = ^WATCHDOG_CYCLES;
    assign wd_fire_c = 1'b0;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            ack_pend    <= 1'b0;
            data_pend   <= 1'b0;
            data_syn_q  <= 1'b0;
            cur_ack     <= 1'b0;
            ack_idx_q   <= '0;
            data_idx_q  <= '0;
            data_pos_q  <= '0;
            cur_pos     <= '0;
            off_q       <= '0;
            vld_dl      <= '0;
            last_dl     <= '0;
            tx_start_q  <= 1'b0;
            ack_done_q  <= 1'b0;
            data_done_q <= 1'b0;
            timeout_q   <= 1'b0;
            tx_type_q   <= '0;
            tx_index_q  <= '0;
            pb_raddr_q  <= '0;
        end else begin
            tx_start_q  <= 1'b0;
            ack_done_q  <= 1'b0;
            data_done_q <= 1'b0;
            timeout_q   <= 1'b0;

            // Valid/last travel alongside the RAM read so they line up with pb_rdata.
            vld_dl[0]  <= take_c;
            last_dl[0] <= take_c && (off_q == LAST);
            for (int i = 1; i < int'(L); i++) begin
                vld_dl[i]  <= vld_dl[i-1];
                last_dl[i] <= last_dl[i-1];
            end
            if (take_c) begin
                pb_raddr_q <= {cur_pos, off_q[OW-1:0]};
                off_q      <= off_q + CW'(1);
            end

            case (state)
                IDLE: begin
                    if (ack_pend) begin
                        ack_pend   <= 1'b0;
                        cur_ack    <= 1'b1;
                        tx_type_q  <= 2'd2;
                        tx_index_q <= ack_idx_q;
                        tx_start_q <= 1'b1;
                        state      <= START;
                    end else if (data_pend) begin
                        data_pend  <= 1'b0;
                        cur_ack    <= 1'b0;
                        tx_type_q  <= data_syn_q ? 2'd0 : 2'd1;
                        tx_index_q <= data_idx_q;
                        cur_pos    <= data_pos_q;
                        tx_start_q <= 1'b1;
                        state      <= START;
                    end
                end
                START: begin
                    off_q <= '0;
                    state <= cur_ack ? WAIT_DONE : STREAM;
                end
                STREAM: begin
                    if (!wd_fire_c && last_dl[L-1])
                        state <= WAIT_DONE;
                end
                WAIT_DONE: begin
                    if (bus.tx_done) begin
                        ack_done_q  <= cur_ack;
                        data_done_q <= !cur_ack;
                        state       <= IDLE;
                    end
                end
            endcase

            // Watchdog abort: report done with timeout and drop any bytes still in flight.
            if (wd_fire_c) begin
                timeout_q   <= 1'b1;
                ack_done_q  <= cur_ack;
                data_done_q <= !cur_ack;
                vld_dl      <= '0;
                last_dl     <= '0;
                state       <= IDLE;
            end

            // Requests are captured in every state; a repeat overwrites the pending fields.
            if (bus.ack_req) begin
                ack_pend  <= 1'b1;
                ack_idx_q <= bus.ack_index;
            end
            if (bus.data_req) begin
                data_pend  <= 1'b1;
                data_syn_q <= bus.data_syn;
                data_idx_q <= bus.data_index;
                data_pos_q <= bus.data_buf_pos;
            end
        end
    end

    assign bus.tx_start   = tx_start_q;
    assign bus.tx_type    = tx_type_q;
    assign bus.tx_index   = tx_index_q;
    assign bus.ack_done   = ack_done_q;
    assign bus.data_done  = data_done_q;
    assign bus.timeout    = timeout_q;
    assign bus.pb_raddr   = pb_raddr_q;
    assign bus.tx_inclk   = vld_dl[L-1];
    assign bus.tx_in_done = last_dl[L-1];
    assign bus.tx_in      = vld_dl[L-1] ? bus.pb_rdata : 8'h00;
endmodule

// File: tb/tb_ffcp_tx_scheduler.sv
// Directed bench for ffcp_tx_scheduler with a synchronous PB RAM model.
module tb_ffcp_tx_scheduler;
    localparam int unsigned WD_CYC = 1500;

    logic clk = 1'b0;
    logic rst;
    int   n_vec = 0;
    int   n_err = 0;

    always #5 clk = ~clk;

    ffcp_tx_scheduler_if #(.PW(5)) bus ();

    ffcp_tx_scheduler #(
        .PB_QUEUE_LEN(32), .DATA_LEN(769), .RAM_LATENCY(2), .WATCHDOG_CYCLES(WD_CYC)
    ) dut (
        .clk(clk), .rst(rst), .bus(bus)
    );

    function automatic logic [7:0] ram_byte(input logic [14:0] a);
        return a[7:0] ^ {a[14:10], a[9:8], 1'b0};
    endfunction

    // PB RAM: data appears two cycles after the readclk that issued the address.
    always @(posedge clk) bus.pb_rdata <= ram_byte(bus.pb_raddr);

    function automatic logic [63:0] outs();
        return 64'({bus.tx_start, bus.tx_type, bus.tx_index, bus.tx_inclk, bus.tx_in,
                    bus.tx_in_done, bus.pb_raddr, bus.ack_done, bus.data_done, bus.timeout});
    endfunction

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_ack(input logic [5:0] idx);
        bus.ack_req = 1'b1; bus.ack_index = idx;
        tick();
        bus.ack_req = 1'b0;
    endtask

    task automatic send_data(input logic syn, input logic [5:0] idx, input logic [4:0] pos);
        bus.data_req = 1'b1; bus.data_syn = syn; bus.data_index = idx; bus.data_buf_pos = pos;
        tick();
        bus.data_req = 1'b0;
    endtask

    task automatic wait_start(input string tag);
        int n = 0;
        while (bus.tx_start !== 1'b1 && n < 20) begin
            tick();
            n++;
        end
        check(tag, 64'(bus.tx_start), 64'd1);
    endtask

    task automatic finish_frame(input string tag, input logic exp_ack);
        bus.tx_done = 1'b1;
        tick();
        bus.tx_done = 1'b0;
        check({tag, "_ack_done"}, 64'(bus.ack_done), 64'(exp_ack));
        check({tag, "_data_done"}, 64'(bus.data_done), 64'(!exp_ack));
        tick();
        check({tag, "_done_drop"}, 64'({bus.ack_done, bus.data_done}), 64'd0);
    endtask

    // Drives readclk (every cycle, or skipping every gap-th) and checks each emerging byte.
    // A full frame keeps readclk high for 5 cycles after the last byte appears.
    task automatic stream(input logic [4:0] pos, input int gap, input int stop_at);
        int         sent = 0;
        int         cyc  = 0;
        int         post = -1;
        logic       rc, acc, p0v = 1'b0, p1v = 1'b0;
        logic [9:0] p0o = '0, p1o = '0;
        logic [14:0] exp_addr = '0;
        forever begin
            if (stop_at < 769 && sent == stop_at) break;
            if (post >= 5) break;
            if (cyc >= 4000) begin
                check("stream_budget", 64'(sent), 64'(stop_at));
                break;
            end
            rc = (sent >= 769) ? 1'b1 : (gap == 0 || (cyc % gap) != 0);
            bus.tx_upstream_readclk = rc;
            tick();
            cyc++;
            acc = rc && (sent < 769);
            p1v = p0v; p1o = p0o;
            p0v = acc; p0o = sent[9:0];
            if (acc) begin
                exp_addr = {pos, sent[9:0]};
                sent++;
            end
            check("inclk", 64'(bus.tx_inclk), 64'(p1v));
            if (p1v) check("tx_in", 64'(bus.tx_in), 64'(ram_byte({pos, p1o})));
            check("in_done", 64'(bus.tx_in_done), 64'(p1v && p1o == 10'd768));
            if (sent > 0) check("raddr", 64'(bus.pb_raddr), 64'(exp_addr));
            check("no_done_in_stream", 64'({bus.ack_done, bus.data_done}), 64'd0);
            if (p1v && p1o == 10'd768) post = 0;
            else if (post >= 0) post++;
        end
        bus.tx_upstream_readclk = 1'b0;
    endtask

    initial begin
        rst = 1'b1;
        bus.data_req = 1'b0; bus.data_syn = 1'b0; bus.data_index = '0; bus.data_buf_pos = '0;
        bus.ack_req = 1'b0; bus.ack_index = '0; bus.tx_upstream_readclk = 1'b0; bus.tx_done = 1'b0;
        repeat (3) tick();
        check("reset_outs", outs(), 64'd0);
        rst = 1'b0;
        tick();
        check("idle_outs", outs(), 64'd0);

        // Ack frame: start 2 cycles after request, no payload, ack_done on tx_done.
        send_ack(6'd5);
        check("t1_start_early", 64'(bus.tx_start), 64'd0);
        tick();
        check("t1_start", 64'(bus.tx_start), 64'd1);
        check("t1_type", 64'(bus.tx_type), 64'd2);
        check("t1_index", 64'(bus.tx_index), 64'd5);
        tick();
        check("t1_start_pulse", 64'(bus.tx_start), 64'd0);
        bus.tx_upstream_readclk = 1'b1;
        repeat (4) begin
            tick();
            check("t1_no_inclk", 64'(bus.tx_inclk), 64'd0);
            check("t1_no_done", 64'(bus.ack_done), 64'd0);
        end
        bus.tx_upstream_readclk = 1'b0;
        finish_frame("t1", 1'b1);

        // msg frame from slot 7.
        send_data(1'b0, 6'd3, 5'd7);
        check("t2_start_early", 64'(bus.tx_start), 64'd0);
        tick();
        check("t2_start", 64'(bus.tx_start), 64'd1);
        check("t2_type", 64'(bus.tx_type), 64'd1);
        check("t2_index", 64'(bus.tx_index), 64'd3);
        tick();
        check("t2_start_pulse", 64'(bus.tx_start), 64'd0);
        stream(5'd7, 0, 769);
        check("t2_last_addr", 64'(bus.pb_raddr), 64'h1F00);
        check("t2_type_held", 64'(bus.tx_type), 64'd1);
        check("t2_index_held", 64'(bus.tx_index), 64'd3);
        finish_frame("t2", 1'b0);

        // syn frame from the top slot with gapped readclk.
        send_data(1'b1, 6'd0, 5'd31);
        tick();
        check("t3_start", 64'(bus.tx_start), 64'd1);
        check("t3_type", 64'(bus.tx_type), 64'd0);
        check("t3_index", 64'(bus.tx_index), 64'd0);
        tick();
        stream(5'd31, 3, 769);
        finish_frame("t3", 1'b0);

        // Simultaneous requests: ack served first, then data.
        bus.ack_req = 1'b1; bus.ack_index = 6'd44;
        bus.data_req = 1'b1; bus.data_syn = 1'b0; bus.data_index = 6'd21; bus.data_buf_pos = 5'd12;
        tick();
        bus.ack_req = 1'b0; bus.data_req = 1'b0;
        tick();
        check("t4_ack_start", 64'(bus.tx_start), 64'd1);
        check("t4_ack_type", 64'(bus.tx_type), 64'd2);
        check("t4_ack_index", 64'(bus.tx_index), 64'd44);
        repeat (2) tick();
        finish_frame("t4a", 1'b1);
        wait_start("t4_data_start");
        check("t4_data_type", 64'(bus.tx_type), 64'd1);
        check("t4_data_index", 64'(bus.tx_index), 64'd21);
        tick();
        stream(5'd12, 4, 769);
        finish_frame("t4b", 1'b0);

        // Reset at offset 100 abandons the frame silently.
        send_data(1'b0, 6'd9, 5'd2);
        wait_start("t5_start");
        tick();
        stream(5'd2, 0, 100);
        rst = 1'b1;
        #1;
        check("t5_async_clear", outs(), 64'd0);
        tick();
        rst = 1'b0;
        bus.tx_done = 1'b1;
        tick();
        bus.tx_done = 1'b0;
        check("t5_no_done", 64'({bus.ack_done, bus.data_done}), 64'd0);
        tick();
        check("t5_no_done_late", 64'({bus.ack_done, bus.data_done, bus.tx_start}), 64'd0);
        send_data(1'b0, 6'd9, 5'd2);
        wait_start("t5_restart");
        tick();
        stream(5'd2, 0, 769);
        finish_frame("t5", 1'b0);

        // tx_done withheld: the FSM waits in WAIT_DONE and does not start the queued ack.
        send_data(1'b0, 6'd63, 5'd0);
        wait_start("t6_start");
        tick();
        stream(5'd0, 0, 769);
        for (int i = 0; i < 200; i++) begin
            bus.ack_req = (i == 20); bus.ack_index = 6'd17;
            tick();
            check("t6_timeout", 64'(bus.timeout), 64'd0);
            check("t6_stuck", 64'({bus.data_done, bus.ack_done, bus.tx_start}), 64'd0);
        end
        bus.ack_req = 1'b0;
        finish_frame("t6", 1'b0);
        wait_start("t6_ack_start");
        check("t6_ack_type", 64'(bus.tx_type), 64'd2);
        check("t6_ack_index", 64'(bus.tx_index), 64'd17);
        tick();
        finish_frame("t6_ack", 1'b1);

`ifdef FFCP_TX_SCHED_WATCHDOG_EN
        // Ack frame with no tx_done: abort WD_CYC cycles after entering WAIT_DONE.
        send_ack(6'd12);
        tick();
        tick();
        for (int i = 1; i < int'(WD_CYC); i++) begin
            tick();
            check("wd_early", 64'({bus.timeout, bus.ack_done}), 64'd0);
        end
        tick();
        check("wd_timeout", 64'(bus.timeout), 64'd1);
        check("wd_ack_done", 64'(bus.ack_done), 64'd1);
        tick();
        check("wd_pulse", 64'({bus.timeout, bus.ack_done}), 64'd0);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
